// File: rtl/ft_mem_pkg.sv
// Shared types and constants for the fault-tolerant data-memory path.
// Codewords are stored verbatim: 32 data bits plus 7 ECC check bits.
package ft_mem_pkg;

   localparam int DW_W = 32;
   localparam int ECC_W = 7;
   localparam int CW_W = DW_W + ECC_W;
   localparam logic [1:0] DSIZE_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

   // Only word-sized accesses whose byte address fits inside the array are accepted.
   function automatic logic isLegalReq(input logic [31:0] addr, input logic [1:0] size, input int aw);
      return ((addr >> (aw + 2)) == 32'd0) && (size == DSIZE_WORD);
   endfunction

endpackage

// File: rtl/ft_sram_array.sv
// Single-port synchronous 1RW codeword array with a registered read port.
// Read data is held between reads so the controller can present it directly.
module ft_sram_array #(
   parameter int AW = 10,
   parameter int DW = 39
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Contents are never cleared; only the read register returns to zero on reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ft_dmem_ctrl.sv
// Word-organised DMEM controller with programmable wait states and address/size fault checks.
// Define FT_DMEM_FAULT_INJ_EN to add the one-shot read-data fault injection ports INJ_ARM/INJ_MASK.
module ft_dmem_ctrl
   import ft_mem_pkg::*;
#(
   parameter int AW = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            DREQ,
   input  logic [31:0]     DADDR,
   input  logic            DRW,
   input  logic [1:0]      DSIZE,
   input  logic [CW_W-1:0] DWDATA,
`ifdef FT_DMEM_FAULT_INJ_EN
   input  logic            INJ_ARM,
   input  logic [CW_W-1:0] INJ_MASK,
`endif
   output logic [CW_W-1:0] DRDATA,
   output logic            nDWAIT,
   output logic            DFAULT
);

   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dmem_state_t     r_state;
   logic [3:0]      r_cnt;
   logic [AW-1:0]   r_word;
   logic            r_rw;
   logic [CW_W-1:0] r_wdata;
   logic            r_nDWait;
   logic            r_fault;

   logic            w_legal;
   logic            w_accept;
   logic            w_issue;
   logic            w_opRw;
   logic [AW-1:0]   w_opWord;
   logic [CW_W-1:0] w_opWdata;
   logic            w_we;
   logic            w_re;
   logic [CW_W-1:0] w_rdata;

   assign w_legal  = isLegalReq(DADDR, DSIZE, AW);
   assign w_accept = (r_state != WAIT) && DREQ && w_legal;

   // With zero wait states the array op is issued on the accepting edge from the live request;
   // otherwise it is issued from the latched request on the last WAIT cycle.
   assign w_issue   = ZERO_WAIT ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));
   assign w_opRw    = ZERO_WAIT ? DRW : r_rw;
   assign w_opWord  = ZERO_WAIT ? DADDR[AW+1:2] : r_word;
   assign w_opWdata = ZERO_WAIT ? DWDATA : r_wdata;

   assign w_we = w_issue && w_opRw && !RST;
   assign w_re = w_issue && !w_opRw && !RST;

   ft_sram_array #(
      .AW(AW),
      .DW(CW_W)
   ) u_array (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_we   (w_we),
      .i_re   (w_re),
      .i_addr (w_opWord),
      .i_wdata(w_opWdata),
      .o_rdata(w_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_word   <= '0;
         r_rw     <= 1'b0;
         r_wdata  <= '0;
         r_nDWait <= 1'b1;
         r_fault  <= 1'b0;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               r_state <= IDLE;
               if (DREQ) begin
                  r_word  <= DADDR[AW+1:2];
                  r_rw    <= DRW;
                  r_wdata <= DWDATA;
                  if (!w_legal) begin
                     r_fault <= 1'b1;
                  end else if (ZERO_WAIT) begin
                     r_state <= DONE;
                  end else begin
                     r_state  <= WAIT;
                     r_cnt    <= CNT_LOAD;
                     r_nDWait <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state  <= DONE;
                  r_nDWait <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_nDWait <= 1'b1;
            end
         endcase
      end
   end

   assign nDWAIT = r_nDWait;
   assign DFAULT = r_fault;

`ifdef FT_DMEM_FAULT_INJ_EN
   logic            r_armed;
   logic [CW_W-1:0] r_injMask;
   logic [CW_W-1:0] r_outMask;

   // The mask is captured alongside the read register so the corrupted word is held like any other read.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_armed   <= 1'b0;
         r_injMask <= '0;
         r_outMask <= '0;
      end else begin
         if (w_re) begin
            r_outMask <= r_armed ? r_injMask : '0;
         end
         if (INJ_ARM) begin
            r_armed   <= 1'b1;
            r_injMask <= INJ_MASK;
         end else if (w_re) begin
            r_armed <= 1'b0;
         end
      end
   end

   assign DRDATA = w_rdata ^ r_outMask;
`else
   assign DRDATA = w_rdata;
`endif

endmodule
